// File: rtl/score_bcd_scheduler.sv
// score_bcd_scheduler
//   One shared iterative binary-to-BCD engine (shift-and-add-3) time-shared
//   between the live score and the high score. A value is converted when its
//   saturated form differs from the last value captured for it. When both
//   differ, the two values alternate (round-robin).
//
// Ports
//   i_clk, i_rst        game clock, synchronous active-high reset
//   i_score             live score (binary, BIN_W bits)
//   i_high_score        live high score (binary, BIN_W bits)
//   o_score_bcd         score digits, [3:0] = ones
//   o_high_bcd          high-score digits, same layout
//   o_score_upd         one-cycle pulse when o_score_bcd is rewritten
//   o_high_upd          one-cycle pulse when o_high_bcd is rewritten
//   o_busy              engine is converting
module score_bcd_scheduler #(
  parameter int BIN_W   = 14,
  parameter int DIGITS  = 4,
  parameter int SAT_VAL = 9999
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [BIN_W-1:0]      i_score,
  input  logic [BIN_W-1:0]      i_high_score,
  output logic [4*DIGITS-1:0]   o_score_bcd,
  output logic [4*DIGITS-1:0]   o_high_bcd,
  output logic                  o_score_upd,
  output logic                  o_high_upd,
  output logic                  o_busy
);

  localparam int BCD_W = 4*DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [BIN_W-1:0] SAT = BIN_W'(SAT_VAL);

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state, state_n;
  logic [BIN_W-1:0]   sat_s, sat_h, cap_s, cap_h;
  logic               pend_s, pend_h, grant_s, grant_h;
  logic               last_high;   // last grant went to the high score
  logic               tgt_high;    // conversion in flight targets high score
  logic [SR_W-1:0]    sr, sr_adj, sr_nxt;
  logic [CNT_W-1:0]   cnt;

  assign sat_s  = (i_score      > SAT) ? SAT : i_score;
  assign sat_h  = (i_high_score > SAT) ? SAT : i_high_score;
  assign pend_s = (sat_s != cap_s);
  assign pend_h = (sat_h != cap_h);
  assign o_busy = (state == CONV);

  // One double-dabble iteration: correct every digit >= 5, then shift.
  always_comb begin
    sr_adj = sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr[BIN_W+4*d +: 4] >= 4'd5)
        sr_adj[BIN_W+4*d +: 4] = sr[BIN_W+4*d +: 4] + 4'd3;
    end
    sr_nxt = sr_adj << 1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  // Score wins a tie unless it was the last one served.
  always_comb begin
    state_n = state;
    grant_s = 1'b0;
    grant_h = 1'b0;
    case (state)
      IDLE: begin
        if (pend_s && (!pend_h || last_high)) begin
          grant_s = 1'b1;
          state_n = CONV;
        end else if (pend_h) begin
          grant_h = 1'b1;
          state_n = CONV;
        end
      end
      CONV:    if (cnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cap_s       <= '0;
      cap_h       <= '0;
      last_high   <= 1'b1;
      tgt_high    <= 1'b0;
      sr          <= '0;
      cnt         <= '0;
      o_score_bcd <= '0;
      o_high_bcd  <= '0;
      o_score_upd <= 1'b0;
      o_high_upd  <= 1'b0;
    end else begin
      o_score_upd <= 1'b0;
      o_high_upd  <= 1'b0;
      if (grant_s || grant_h) begin
        if (grant_s) cap_s <= sat_s;
        else         cap_h <= sat_h;
        sr        <= {BCD_W'(0), (grant_s ? sat_s : sat_h)};
        cnt       <= CNT_W'(BIN_W-1);
        last_high <= grant_h;
        tgt_high  <= grant_h;
      end else if (state == CONV) begin
        sr  <= sr_nxt;
        cnt <= cnt - CNT_W'(1);
        // Last iteration: the post-shift digits are final.
        if (cnt == '0) begin
          if (tgt_high) begin
            o_high_bcd <= sr_nxt[SR_W-1 -: BCD_W];
            o_high_upd <= 1'b1;
          end else begin
            o_score_bcd <= sr_nxt[SR_W-1 -: BCD_W];
            o_score_upd <= 1'b1;
          end
        end
      end
    end
  end

endmodule
